// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
package counter_pkg;

   typedef logic [1:0] cnt_mode_t;

   // Code 2'b11 is not named; the counter treats it the same as wrap.
   localparam cnt_mode_t MODE_WRAP    = 2'b00;
   localparam cnt_mode_t MODE_SAT     = 2'b01;
   localparam cnt_mode_t MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/cnt_next.sv
// Combinational next-count step for a modulo-MOD counter.
// Also flags when q sits at the terminal value for the current direction.
module cnt_next
   import counter_pkg::*;
#(
   parameter int unsigned       WIDTH = 4,
   parameter longint unsigned   MOD   = 16
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  cnt_mode_t        mode,
   output logic [WIDTH-1:0] next_q,
   output logic             at_term,
   output logic             set_done
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);

   assign at_term = up ? (q == MAXV) : (q == '0);

   always_comb begin
      next_q   = q;
      set_done = 1'b0;
      if (!at_term) begin
         next_q = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end else begin
         case (mode)
            MODE_SAT: begin
               next_q = q;
            end
            MODE_ONESHOT: begin
               next_q   = q;
               set_done = 1'b1;
            end
            // Both wrap and the unused 2'b11 code fold back into range.
            default: begin
               next_q = up ? '0 : MAXV;
            end
         endcase
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, clear and wrap/saturate/one-shot terminal modes.
// Holds the q and done registers; stepping arithmetic lives in cnt_next.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned       WIDTH = 4,
   parameter longint unsigned   MOD   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  cnt_mode_t        mode,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             done
);

   generate
      if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_params
         $error("mod_updown_counter: illegal WIDTH/MOD combination");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);

   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] load_clamped;
   logic             at_term;
   logic             set_done;

   cnt_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .q        (q),
      .up       (up),
      .mode     (mode),
      .next_q   (next_q),
      .at_term  (at_term),
      .set_done (set_done)
   );

   // Out-of-range load values must never reach q, so they pin to the top code.
   assign load_clamped = (64'(load_val) >= MOD) ? MAXV : load_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q    <= '0;
         done <= 1'b0;
      end else if (clr) begin
         q    <= '0;
         done <= 1'b0;
      end else if (load) begin
         q    <= load_clamped;
         done <= 1'b0;
      end else if (en && !done) begin
         q <= next_q;
         if (set_done) begin
            done <= 1'b1;
         end
      end
   end

   assign tc = en & at_term & ~done & ~clr & ~load;
   assign qb = ~q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a MOD=10 instance plus a MOD=16 instance on shared inputs.
module tb_mod_updown_counter;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic       en;
   logic       up;
   logic [1:0] mode;

   logic [3:0] q10, qb10, q16, qb16;
   logic       tc10, done10, tc16, done16;

   int tests = 0;
   int fails = 0;

   mod_updown_counter #(.WIDTH(4), .MOD(10)) d10 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .mode(mode), .q(q10), .qb(qb10), .tc(tc10), .done(done10)
   );

   mod_updown_counter #(.WIDTH(4), .MOD(16)) d16 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .mode(mode), .q(q16), .qb(qb16), .tc(tc16), .done(done16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic u, input logic [1:0] m);
      clr = c; load = l; load_val = lv; en = e; up = u; mode = m;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int         dnQ  [4] = '{1, 0, 9, 8};
   logic       dnTc [4] = '{0, 0, 1, 0};
   int         satQ [5] = '{14, 15, 15, 15, 15};
   logic       satTc[5] = '{0, 0, 1, 1, 1};

   initial begin
      rst = 1'b0;
      applyStimulus(0, 0, 4'd0, 0, 1, 2'b00);
      #1;
      checkOutput("reset q", q10, 0);
      checkOutput("reset qb", qb10, 4'hF);
      checkOutput("reset tc", tc10, 0);
      checkOutput("reset done", done10, 0);
      checkOutput("reset q16", q16, 0);
      checkOutput("reset qb16", qb16, 4'hF);
      checkOutput("reset done16", done16, 0);

      // Release reset between edges, then wrap-count up through 9 -> 0.
      #5;
      rst = 1'b1;
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b00);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("wrap tc @%0d", i % 10), tc10, ((i % 10) == 9));
         tick();
         checkOutput($sformatf("wrap q step %0d", i), q10, (i + 1) % 10);
      end
      checkOutput("wrap q16", q16, 12);

      // Down-count wrap from a loaded 2.
      applyStimulus(0, 1, 4'd2, 1, 0, 2'b00);
      checkOutput("load tc", tc10, 0);
      tick();
      checkOutput("load 2", q10, 2);
      applyStimulus(0, 0, 4'd0, 1, 0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("down tc %0d", i), tc10, dnTc[i]);
         tick();
         checkOutput($sformatf("down q %0d", i), q10, dnQ[i]);
      end

      // Saturate: MOD=16 from 13, MOD=10 clamps 13 to 9 and sits there.
      applyStimulus(0, 1, 4'd13, 1, 1, 2'b01);
      tick();
      checkOutput("load13 q16", q16, 13);
      checkOutput("load13 clamp q10", q10, 9);
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b01);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("sat tc16 %0d", i), tc16, satTc[i]);
         checkOutput($sformatf("sat tc10 %0d", i), tc10, 1);
         tick();
         checkOutput($sformatf("sat q16 %0d", i), q16, satQ[i]);
         checkOutput($sformatf("sat q10 %0d", i), q10, 9);
      end

      // One-shot on MOD=10 from 7.
      applyStimulus(0, 1, 4'd7, 1, 1, 2'b10);
      tick();
      checkOutput("os load q", q10, 7);
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b10);
      checkOutput("os tc at 7", tc10, 0);
      tick();
      checkOutput("os q 8", q10, 8);
      checkOutput("os tc at 8", tc10, 0);
      tick();
      checkOutput("os q 9", q10, 9);
      checkOutput("os done before", done10, 0);
      checkOutput("os tc at 9", tc10, 1);
      tick();
      checkOutput("os q hold", q10, 9);
      checkOutput("os done set", done10, 1);
      checkOutput("os tc after done", tc10, 0);
      applyStimulus(0, 0, 4'd0, 0, 1, 2'b10);
      tick();
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b10);
      checkOutput("os frozen tc", tc10, 0);
      tick();
      checkOutput("os frozen q", q10, 9);
      checkOutput("os frozen done", done10, 1);
      applyStimulus(0, 1, 4'd3, 1, 1, 2'b10);
      tick();
      checkOutput("os reload q", q10, 3);
      checkOutput("os reload done", done10, 0);
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b10);
      tick();
      checkOutput("os resume q", q10, 4);

      // clr beats load beats count.
      applyStimulus(1, 1, 4'd5, 1, 1, 2'b10);
      checkOutput("prio tc", tc10, 0);
      tick();
      checkOutput("prio q", q10, 0);

      // Load clamp boundaries.
      applyStimulus(0, 1, 4'd12, 0, 1, 2'b00);
      tick();
      checkOutput("clamp12 q10", q10, 9);
      checkOutput("clamp12 q16", q16, 12);
      applyStimulus(0, 1, 4'd10, 0, 1, 2'b00);
      tick();
      checkOutput("clamp10 q10", q10, 9);
      checkOutput("clamp10 q16", q16, 10);
      applyStimulus(0, 1, 4'd8, 0, 1, 2'b00);
      tick();
      checkOutput("load8 q10", q10, 8);

      // Mode 2'b11 behaves as wrap.
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b11);
      tick();
      checkOutput("m11 q 9", q10, 9);
      checkOutput("m11 tc", tc10, 1);
      tick();
      checkOutput("m11 wrap q", q10, 0);

      // Asynchronous reset with done set.
      applyStimulus(0, 1, 4'd8, 1, 1, 2'b10);
      tick();
      applyStimulus(0, 0, 4'd0, 1, 1, 2'b10);
      tick();
      checkOutput("ar q 9", q10, 9);
      tick();
      checkOutput("ar done pre", done10, 1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("ar q", q10, 0);
      checkOutput("ar done", done10, 0);
      checkOutput("ar qb", qb10, 4'hF);
      checkOutput("ar tc", tc10, 0);
      #1;
      rst = 1'b1;
      tick();
      checkOutput("ar first edge q", q10, 1);
      checkOutput("ar first edge done", done10, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
